// File: rtl/ysyx_23060061_lsu_pkg.sv
// Shared constants for the ysyx_23060061 load/store unit:
// funct3 codes, FSM state encoding and byte-mask constants.
package ysyx_23060061_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_REQ  = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_RESP     = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

endpackage

// File: rtl/ysyx_23060061_lsu_align.sv
// Combinational lane alignment: store mask/data placement, load
// extraction with sign/zero extension, and access legality check.
module ysyx_23060061_lsu_align
  import ysyx_23060061_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        bad
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    st_mask = MASK_NONE;
    st_data = wdata;
    unique case (funct3)
      F3_B: begin
        st_mask = MASK_B << off;
        st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        st_mask = MASK_H << off;
        st_data = {2{wdata[15:0]}};
      end
      F3_W: begin
        st_mask = MASK_W;
        st_data = wdata;
      end
      default: begin
        st_mask = MASK_NONE;
        st_data = wdata;
      end
    endcase
  end

  always_comb begin
    ld_data = sh;
    unique case (funct3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   ld_data = {24'h0, sh[7:0]};
      F3_HU:   ld_data = {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  // unsigned variants have no store form
  always_comb begin
    bad = 1'b0;
    unique case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = |off;
      F3_BU:   bad = wen;
      F3_HU:   bad = wen | off[0];
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit between execute and the word-addressed data SRAM bus;
// one transaction at a time with request/response handshakes and timeout.
module ysyx_23060061_lsu
  import ysyx_23060061_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e        state_q, state_d;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        idle;
  logic        tmo;
  logic        set_resp;
  logic        err_d;
  logic [31:0] rdata_d;

  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic        a_wen;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        bad;

  assign idle = (state_q == S_IDLE);

  // legality is judged on the live request while idle
  assign a_f3  = idle ? req_funct3    : f3_q;
  assign a_off = idle ? req_addr[1:0] : addr_q[1:0];
  assign a_wen = idle ? req_wen       : wen_q;

  ysyx_23060061_lsu_align u_align (
    .funct3  (a_f3),
    .off     (a_off),
    .wen     (a_wen),
    .wdata   (wdata_q),
    .rdata   (mem_rdata),
    .st_mask (st_mask),
    .st_data (st_data),
    .ld_data (ld_data),
    .bad     (bad)
  );

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    set_resp = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (bad) begin
            state_d  = S_RESP;
            set_resp = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        if (mem_ready && mem_rvalid) begin
          state_d  = S_RESP;
          set_resp = 1'b1;
          rdata_d  = wen_q ? '0 : ld_data;
        end else if (tmo) begin
          state_d  = S_RESP;
          set_resp = 1'b1;
          err_d    = 1'b1;
        end else if (mem_ready) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_rvalid) begin
          state_d  = S_RESP;
          set_resp = 1'b1;
          rdata_d  = wen_q ? '0 : ld_data;
        end else if (tmo) begin
          state_d  = S_RESP;
          set_resp = 1'b1;
          err_d    = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (idle && req_valid) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
      end
      if (set_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
      if (idle && state_d == S_MEM_REQ) begin
        cnt_q <= '0;
      end else if (state_q == S_MEM_REQ ||
                   state_q == S_MEM_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state_q == S_MEM_REQ);
  assign mem_wen    = wen_q;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = st_data;
  assign mem_wmask  = (mem_valid && wen_q) ? st_mask : MASK_NONE;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Self-checking bench for ysyx_23060061_lsu: directed corner cases
// plus random transactions against a spec-level reference model.
module tb_ysyx_23060061_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errs;
  int checks;

  ysyx_23060061_lsu #(
    .TIMEOUT_CYCLES (8),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input int f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit wen, input int f3,
                               input logic [31:0] a);
    bit legal;
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (wen && f3 >= 4) legal = 0;
    if (!legal) return 1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int f3,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] span;
    int off;
    off = int'(a % 4);
    v = w >> (8 * off);
    if (m_size(f3) == 4) return v;
    span = (m_size(f3) == 1) ? 32'd256 : 32'd65536;
    v = v % span;
    if (f3 < 4 && v >= span / 2) v = v - span;
    return v;
  endfunction

  function automatic logic [3:0] m_mask(input int f3,
                                        input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (m_size(f3) == 1) return 4'(1 << off);
    if (m_size(f3) == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int f3,
                                          input logic [31:0] w);
    if (m_size(f3) == 1) return (w % 256) * 32'h01010101;
    if (m_size(f3) == 2) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  task automatic do_txn(input bit wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int rdly,
                        input int vdly, input int hold);
    bit          e;
    logic [31:0] exp_rd;
    e = m_err(wen, int'(f3), a);
    exp_rd = (e || wen) ? 32'h0 : m_load(int'(f3), a, rw);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    if (e) begin
      chk("err_no_bus", {31'h0, mem_valid}, 32'h0);
      chk("err_resp_valid", {31'h0, resp_valid}, 32'h1);
    end else begin
      for (int i = 0; i < rdly; i++) begin
        chk("stall_mem_valid", {31'h0, mem_valid}, 32'h1);
        chk("stall_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("stall_mem_wmask", {28'h0, mem_wmask},
            {28'h0, wen ? m_mask(int'(f3), a) : 4'h0});
        tick();
      end
      chk("mem_valid", {31'h0, mem_valid}, 32'h1);
      chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("mem_wen", {31'h0, mem_wen}, {31'h0, wen});
      chk("mem_wmask", {28'h0, mem_wmask},
          {28'h0, wen ? m_mask(int'(f3), a) : 4'h0});
      if (wen) chk("mem_wdata", mem_wdata, m_wdata(int'(f3), wd));
      mem_ready = 1'b1;
      if (vdly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rw;
      end
      tick();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (vdly > 0) begin
        for (int i = 0; i < vdly - 1; i++) begin
          chk("wait_mem_valid", {31'h0, mem_valid}, 32'h0);
          chk("wait_resp_valid", {31'h0, resp_valid}, 32'h0);
          tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rw;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      chk("resp_valid", {31'h0, resp_valid}, 32'h1);
    end
    chk("resp_err", {31'h0, resp_err}, {31'h0, e});
    chk("resp_rdata", resp_rdata, exp_rd);
    for (int i = 0; i < hold; i++) begin
      chk("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
      chk("hold_rdata", resp_rdata, exp_rd);
      tick();
    end
    resp_ready = 1'b1;
    chk("resp_valid_final", {31'h0, resp_valid}, 32'h1);
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", {31'h0, resp_valid}, 32'h0);
    chk("req_ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    resp_ready = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_wmask", {28'h0, mem_wmask}, 32'h0);

    do_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0,
           32'h8A00_0000, 0, 0, 0);
    do_txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD,
           32'h0, 0, 1, 0);
    do_txn(1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0);
    do_txn(1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 1);
    do_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0,
           32'hF00D_1234, 3, 2, 4);

    // timeout with mem_ready never asserted
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h8000_0010;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_pending", {31'h0, resp_valid}, 32'h0);
      tick();
    end
    chk("tmo_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("tmo_err", {31'h0, resp_err}, 32'h1);
    chk("tmo_rdata", resp_rdata, 32'h0);
    chk("tmo_mem_valid", {31'h0, mem_valid}, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("late_rvalid2", {31'h0, resp_valid}, 32'h0);
    chk("late_req_ready", {31'h0, req_ready}, 32'h1);

    // reset while waiting for read data
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h8000_0020;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("wait_no_valid", {31'h0, mem_valid}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mrst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("mrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_rvalid", {31'h0, resp_valid}, 32'h0);
    chk("stray_req_ready", {31'h0, req_ready}, 32'h1);

    for (int n = 0; n < 200; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h8000_0000 | 32'($urandom_range(0, 255));
      do_txn(1'($urandom), f3, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
